serial_sub_ctrl: RTL and testbench

Bit-serial arithmetic controller that sequences a single 1-bit full-subtractor/full-adder cell over WIDTH-bit operands, LSB first. The cell is realised as two 8:1 truth-table muxes indexed by {a_bit, b_bit, c_bit}. The controller configures the cell tables according to the requested operation, steps the bit index, and recirculates the borrow/carry. It accumulates the result and signals completion with a start/busy/done handshake. It sits between operand registers and any consumer that needs multi-bit subtract/add without a parallel ripple chain.

---
 rtl/serial_sub_ctrl.sv | 126 ++++++++++++
 tb/tb_serial_sub_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial subtract/add controller driving a 1-bit truth-table cell
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [7:0] OUT_TBL    = 8'h96;
    localparam logic [7:0] BORROW_TBL = 8'h8E;
    localparam logic [7:0] CARRY_TBL  = 8'hE8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_op;
    logic [IDX_W-1:0]   r_idx;
    logic               r_c;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_result;
    logic               r_flag;

    logic [7:0]         w_c_tbl;
    logic [2:0]         w_sel;
    logic               w_out;
    logic               w_c_nxt;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic               w_last;
    logic               w_accept;

    // Cell: two 8:1 muxes indexed by {a_bit, b_bit, c_bit}
    assign w_c_tbl = r_op ? CARRY_TBL : BORROW_TBL;
    assign w_sel   = {r_a[r_idx], r_b[r_idx], r_c};
    assign w_out   = OUT_TBL[w_sel];
    assign w_c_nxt = w_c_tbl[w_sel];
    assign w_last  = (r_idx == IDX_W'(WIDTH - 1));

    generate
        if (WIDTH == 1) begin : g_acc_one
            assign w_acc_nxt = w_out;
        end else begin : g_acc_shift
            assign w_acc_nxt = {w_out, r_acc[WIDTH-1:1]};
        end
    endgenerate

    // The edge that leaves DONE also samples start, so back-to-back
    // operations run every WIDTH+1 cycles.
    assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = w_accept ? ST_RUN : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= 1'b0;
            r_idx    <= '0;
            r_c      <= 1'b0;
            r_acc    <= '0;
            r_result <= '0;
            r_flag   <= 1'b0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_op  <= op;
            r_idx <= '0;
            r_c   <= 1'b0;
            r_acc <= '0;
        end else if (r_state == ST_RUN) begin
            r_acc <= w_acc_nxt;
            r_c   <= w_c_nxt;
            r_idx <= r_idx + IDX_W'(1);
            if (w_last) begin
                r_result <= w_acc_nxt;
                r_flag   <= w_c_nxt;
            end
        end
    end

    assign result = r_result;
    assign flag   = r_flag;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb/tb_serial_sub_ctrl.sv - directed self-checking bench for serial_sub_ctrl
module tb_serial_sub_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             flag;

    int n_total;
    int n_bad;

    serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .flag   (flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b1; op = 1'b1; a = 8'hFF; b = 8'h01;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); @(negedge clk);
            n_total++;
            if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h00 || flag !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_state cyc=%0d busy=%b done=%b result=%h flag=%b want 0 0 00 0",
                         i, busy, done, result, flag);
            end
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        n_total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    // Runs one operation from IDLE and checks every cycle through E_WIDTH+1.
    task automatic run_op(input string name, input logic t_op, input logic [7:0] t_a,
                          input logic [7:0] t_b, input logic [7:0] exp_res, input logic exp_flag);
        start = 1'b1; op = t_op; a = t_a; b = t_b;
        @(posedge clk); @(negedge clk);
        start = 1'b0; op = ~t_op; a = 8'h5A; b = 8'hC3;
        for (int i = 0; i < WIDTH; i++) begin
            n_total++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_bad++;
                $display("FAIL %s_run cyc=%0d busy=%b done=%b want 1 0", name, i, busy, done);
            end
            @(posedge clk); @(negedge clk);
        end
        n_total++;
        if (done !== 1'b1 || busy !== 1'b0 || result !== exp_res || flag !== exp_flag) begin
            n_bad++;
            $display("FAIL %s_done done=%b busy=%b result=%h flag=%b want 1 0 %h %b",
                     name, done, busy, result, flag, exp_res, exp_flag);
        end
        @(posedge clk); @(negedge clk);
        n_total++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== exp_res || flag !== exp_flag) begin
            n_bad++;
            $display("FAIL %s_after done=%b busy=%b result=%h flag=%b want 0 0 %h %b",
                     name, done, busy, result, flag, exp_res, exp_flag);
        end
    endtask

    task automatic test_subtract;
        run_op("sub_05_03", 1'b0, 8'h05, 8'h03, 8'h02, 1'b0);
        run_op("sub_03_05", 1'b0, 8'h03, 8'h05, 8'hFE, 1'b1);
        run_op("sub_00_00", 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic test_add;
        run_op("add_FF_01", 1'b1, 8'hFF, 8'h01, 8'h00, 1'b1);
        run_op("add_7F_01", 1'b1, 8'h7F, 8'h01, 8'h80, 1'b0);
    endtask

    task automatic test_back_to_back;
        int n_done;
        n_done = 0;
        start = 1'b1; op = 1'b0; a = 8'h05; b = 8'h03;
        @(posedge clk); @(negedge clk);
        op = 1'b0; a = 8'hAA; b = 8'h55;
        for (int e = 1; e <= 18; e++) begin
            start = (e == 3 || e == 8 || e == 9);
            @(posedge clk); @(negedge clk);
            if (done === 1'b1) n_done++;
            n_total++;
            if (done !== (e == 8 || e == 17)) begin
                n_bad++;
                $display("FAIL b2b_done e=%0d done=%b want %b", e, done, (e == 8 || e == 17));
            end
            if (e >= 8 && e < 17) begin
                n_total++;
                if (result !== 8'h02 || flag !== 1'b0) begin
                    n_bad++;
                    $display("FAIL b2b_first e=%0d result=%h flag=%b want 02 0", e, result, flag);
                end
            end
            if (e >= 17) begin
                n_total++;
                if (result !== 8'h55 || flag !== 1'b0) begin
                    n_bad++;
                    $display("FAIL b2b_second e=%0d result=%h flag=%b want 55 0", e, result, flag);
                end
            end
        end
        start = 1'b0;
        n_total++;
        if (n_done != 2) begin
            n_bad++;
            $display("FAIL b2b_pulses got=%0d want 2", n_done);
        end
    endtask

    task automatic test_reset_mid_run;
        int n_done;
        n_done = 0;
        start = 1'b1; op = 1'b0; a = 8'h05; b = 8'h03;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk); @(negedge clk);
        end
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        n_total++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h00 || flag !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_state busy=%b done=%b result=%h flag=%b want 0 0 00 0",
                     busy, done, result, flag);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) n_done++;
        end
        n_total++;
        if (n_done != 0) begin
            n_bad++;
            $display("FAIL midrst_quiet active_cycles=%0d want 0", n_done);
        end
        run_op("post_rst", 1'b0, 8'h10, 8'h20, 8'hF0, 1'b1);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
        @(negedge clk);
        test_reset;
        test_subtract;
        test_add;
        test_back_to_back;
        test_reset_mid_run;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
